// File: rtl/mc_cmd_sequencer.sv
// Closed-page DDR5 command sequencer: takes one queued request at a time, decodes the address
// and walks ACT0/ACT1/CAS0/CAS1/PRE with the configured timing gaps between them.
module mc_cmd_sequencer #(
  parameter int T_RCD   = 39,
  parameter int T_RTP   = 18,
  parameter int T_CWL   = 38,
  parameter int T_BURST = 8,
  parameter int T_WR    = 72,
  parameter int T_RP    = 39
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [35:0] req_addr,
  output logic        cmd_valid,
  output logic [2:0]  cmd_type,
  output logic        cmd_channel,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_bank,
  output logic [15:0] cmd_row,
  output logic [5:0]  cmd_col,
  output logic        done,
  output logic        err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ACT0     = 4'd1;
  localparam logic [3:0] S_ACT1     = 4'd2;
  localparam logic [3:0] S_WAIT_RCD = 4'd3;
  localparam logic [3:0] S_CAS0     = 4'd4;
  localparam logic [3:0] S_CAS1     = 4'd5;
  localparam logic [3:0] S_WAIT_PRE = 4'd6;
  localparam logic [3:0] S_PRE      = 4'd7;
  localparam logic [3:0] S_WAIT_RP  = 4'd8;

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_ACT0 = 3'd1;
  localparam logic [2:0] C_ACT1 = 3'd2;
  localparam logic [2:0] C_RD0  = 3'd3;
  localparam logic [2:0] C_RD1  = 3'd4;
  localparam logic [2:0] C_WR0  = 3'd5;
  localparam logic [2:0] C_WR1  = 3'd6;
  localparam logic [2:0] C_PRE  = 3'd7;

  // Wait-state lengths: the two command cycles bounding each gap are not part of the wait.
  localparam int RCD_GAP = T_RCD - 2;
  localparam int RD_GAP  = T_RTP - 2;
  localparam int WR_GAP  = T_CWL + T_BURST + T_WR - 2;
  localparam int RP_GAP  = T_RP - 2;

  logic [3:0]  state;
  logic [3:0]  nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic        is_wr;
  logic        accept;
  logic        illegal;
  int          pre_gap;
  logic        unused_addr;

  assign unused_addr = ^{req_addr[35:34], req_addr[5:0]};

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [2:0] cmd_code(input logic [3:0] st, input logic wr);
    case (st)
      S_ACT0:  return C_ACT0;
      S_ACT1:  return C_ACT1;
      S_CAS0:  return wr ? C_WR0 : C_RD0;
      S_CAS1:  return wr ? C_WR1 : C_RD1;
      S_PRE:   return C_PRE;
      default: return C_NOP;
    endcase
  endfunction

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    accept  = 1'b0;
    illegal = 1'b0;
    pre_gap = is_wr ? WR_GAP : RD_GAP;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (req_op == 2'd3) illegal = 1'b1;
          else                nxt = S_ACT0;
        end
      end
      S_ACT0: nxt = S_ACT1;
      S_ACT1: begin
        if (RCD_GAP > 0) begin
          nxt     = S_WAIT_RCD;
          cnt_nxt = 16'(RCD_GAP - 1);
        end else begin
          nxt = S_CAS0;
        end
      end
      S_WAIT_RCD: begin
        if (cnt == 16'd0) nxt = S_CAS0;
        else              cnt_nxt = cnt - 16'd1;
      end
      S_CAS0: nxt = S_CAS1;
      S_CAS1: begin
        if (pre_gap > 0) begin
          nxt     = S_WAIT_PRE;
          cnt_nxt = 16'(pre_gap - 1);
        end else begin
          nxt = S_PRE;
        end
      end
      S_WAIT_PRE: begin
        if (cnt == 16'd0) nxt = S_PRE;
        else              cnt_nxt = cnt - 16'd1;
      end
      S_PRE: begin
        if (RP_GAP > 0) begin
          nxt     = S_WAIT_RP;
          cnt_nxt = 16'(RP_GAP - 1);
        end else begin
          nxt = S_IDLE;
        end
      end
      S_WAIT_RP: begin
        if (cnt == 16'd0) nxt = S_IDLE;
        else              cnt_nxt = cnt - 16'd1;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 16'd0;
      is_wr       <= 1'b0;
      req_ready   <= 1'b1;
      cmd_valid   <= 1'b0;
      cmd_type    <= C_NOP;
      cmd_channel <= 1'b0;
      cmd_bg      <= 3'd0;
      cmd_bank    <= 2'd0;
      cmd_row     <= 16'd0;
      cmd_col     <= 6'd0;
      done        <= 1'b0;
      err         <= 1'b0;
      rd_count    <= 16'd0;
      wr_count    <= 16'd0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      req_ready <= (nxt == S_IDLE);
      cmd_valid <= (cmd_code(nxt, is_wr) != C_NOP);
      cmd_type  <= cmd_code(nxt, is_wr);
      done      <= (nxt == S_PRE);
      err       <= accept && illegal;
      if (accept) is_wr <= (req_op == 2'd1);
      if (accept && !illegal) begin
        cmd_channel <= req_addr[6];
        cmd_bg      <= req_addr[9:7];
        cmd_bank    <= req_addr[11:10];
        cmd_row     <= req_addr[33:18];
        cmd_col     <= req_addr[17:12];
      end else if (nxt == S_IDLE || nxt == S_WAIT_RP) begin
        cmd_channel <= 1'b0;
        cmd_bg      <= 3'd0;
        cmd_bank    <= 2'd0;
        cmd_row     <= 16'd0;
        cmd_col     <= 6'd0;
      end
      if (nxt == S_PRE && is_wr)  wr_count <= sat_inc(wr_count);
      if (nxt == S_PRE && !is_wr) rd_count <= sat_inc(rd_count);
    end
  end

endmodule

// File: tb/tb_mc_cmd_sequencer.sv
// Scoreboard bench for mc_cmd_sequencer: stimulus predicts command events from the timing rules,
// a negedge monitor pops and compares them against whatever the sequencer presents.
module tb_mc_cmd_sequencer;

  localparam int T_RCD = 39, T_RTP = 18, T_CWL = 38, T_BURST = 8, T_WR = 72, T_RP = 39;

  logic        clk, rst, req_valid, req_ready;
  logic [1:0]  req_op;
  logic [35:0] req_addr;
  logic        cmd_valid, cmd_channel, done, err;
  logic [2:0]  cmd_type, cmd_bg;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_row, rd_count, wr_count;
  logic [5:0]  cmd_col;

  mc_cmd_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_channel(cmd_channel),
    .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col), .done(done),
    .err(err), .rd_count(rd_count), .wr_count(wr_count)
  );

  typedef struct {
    int          cyc;
    logic [2:0]  typ;
    logic [27:0] fields;
    logic        dn;
    logic [15:0] rdc;
    logic [15:0] wrc;
  } ev_t;

  ev_t  exp_q[$];
  int   err_q[$];
  int   cyc = 0;
  int   n_pass = 0, n_total = 0;
  int   busy_lo = -1, busy_hi = -2;
  int   m_rd = 0, m_wr = 0;
  logic [15:0] c_rd = 16'd0, c_wr = 16'd0;
  logic mon_en = 1'b0;
  ev_t  e;
  logic exp_ready, exp_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
  endtask

  task automatic flag(input string name, input int a, input int b);
    n_total++;
    $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, a, b);
  endtask

  function automatic logic [27:0] decode(input logic [35:0] a);
    logic [63:0] v;
    v = 64'(a);
    return {1'((v >> 6) % 2), 3'((v >> 7) % 8), 2'((v >> 10) % 4), 16'((v >> 18) % 65536),
            6'((v >> 12) % 64)};
  endfunction

  task automatic push_ev(input int c, input logic [2:0] t, input logic [27:0] f, input logic dn);
    ev_t x;
    x.cyc = c; x.typ = t; x.fields = f; x.dn = dn;
    x.rdc = 16'(m_rd); x.wrc = 16'(m_wr);
    exp_q.push_back(x);
  endtask

  // Reference timing: ACT0 one cycle after accept, CAS T_RCD later, PRE after read or write recovery.
  task automatic model_issue(input int n, input logic [1:0] op, input logic [35:0] a);
    int ca, cc, cp;
    logic wr;
    logic [27:0] f;
    if (op == 2'd3) begin
      err_q.push_back(n + 1);
      return;
    end
    wr = (op == 2'd1);
    f  = decode(a);
    ca = n + 1;
    cc = ca + T_RCD;
    cp = wr ? cc + T_CWL + T_BURST + T_WR : cc + T_RTP;
    push_ev(ca, 3'd1, f, 1'b0);
    push_ev(ca + 1, 3'd2, f, 1'b0);
    push_ev(cc, wr ? 3'd5 : 3'd3, f, 1'b0);
    push_ev(cc + 1, wr ? 3'd6 : 3'd4, f, 1'b0);
    if (wr) m_wr = (m_wr >= 65535) ? 65535 : m_wr + 1;
    else    m_rd = (m_rd >= 65535) ? 65535 : m_rd + 1;
    push_ev(cp, 3'd7, f, 1'b1);
    busy_lo = ca;
    busy_hi = cp + T_RP - 2;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_ready = !(cyc >= busy_lo && cyc <= busy_hi);
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      if (cmd_valid) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          flag("unexpected_cmd_type", int'(cmd_type), 0);
        end else begin
          e = exp_q.pop_front();
          check("cmd_type", 64'(cmd_type), 64'(e.typ));
          check("cmd_fields", 64'({cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col}), 64'(e.fields));
          check("done", 64'(done), 64'(e.dn));
          if (e.dn) begin
            check("rd_count_at_pre", 64'(rd_count), 64'(e.rdc));
            check("wr_count_at_pre", 64'(wr_count), 64'(e.wrc));
            c_rd = e.rdc;
            c_wr = e.wrc;
          end
        end
      end else begin
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          flag("missed_cmd_cycle", cyc, e.cyc);
        end
        check("idle_cmd_type", 64'(cmd_type), 64'd0);
        check("idle_done", 64'(done), 64'd0);
      end
      exp_err = (err_q.size() > 0 && err_q[0] == cyc);
      if (exp_err) void'(err_q.pop_front());
      check("err", 64'(err), 64'(exp_err));
      if (exp_ready) begin
        check("idle_fields", 64'({cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col}), 64'd0);
        check("idle_rd_count", 64'(rd_count), 64'(c_rd));
        check("idle_wr_count", 64'(wr_count), 64'(c_wr));
      end
    end
  end

  function automatic logic [35:0] rand_addr();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[35:0];
  endfunction

  task automatic send(input logic [1:0] op, input logic [35:0] a, output int n);
    int guard;
    guard = 0;
    req_valid = 1'b1;
    while (!req_ready && guard < 1000) begin
      req_op   = 2'($urandom_range(0, 3));
      req_addr = rand_addr();
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready) begin
      flag("accept_timeout", guard, 0);
      req_valid = 1'b0;
      n = -1;
      return;
    end
    req_op   = op;
    req_addr = a;
    n = cyc;
    model_issue(cyc, op, a);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom_range(0, 3));
    req_addr  = rand_addr();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() > 0 || err_q.size() > 0 || cyc <= busy_hi) && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 2000) flag("drain_timeout", guard, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n1, n2, nr;
    logic [35:0] base;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = 36'd0;
    base = 36'h0_0004_0C40;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_cmd", 64'({cmd_valid, cmd_type}), 64'd0);
    check("rst_fields", 64'({cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col}), 64'd0);
    check("rst_pulses", 64'({done, err}), 64'd0);
    check("rst_counts", 64'({rd_count, wr_count}), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    send(2'd0, base, n1);
    drain();
    check("read_fields_decoded", 64'(decode(base)), 64'({1'b1, 3'd0, 2'd3, 16'd1, 6'd0}));
    send(2'd1, base, n1);
    drain();

    send(2'd0, base, n1);
    send(2'd2, rand_addr(), n2);
    check("b2b_accept_gap", 64'(n2 - n1), 64'd96);
    drain();

    send(2'd3, rand_addr(), n1);
    drain();

    send(2'd0, rand_addr(), nr);
    while (cyc < nr + 20) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_q.delete();
    err_q.delete();
    busy_hi = cyc;
    m_rd = 0; m_wr = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    c_rd = 16'd0; c_wr = 16'd0;
    check("midrst_ready", 64'(req_ready), 64'd1);
    check("midrst_cmd", 64'({cmd_valid, cmd_type, done, err}), 64'd0);
    check("midrst_counts", 64'({rd_count, wr_count}), 64'd0);
    repeat (100) @(posedge clk);
    #1;
    send(2'd0, rand_addr(), n1);
    drain();

    force dut.rd_count = 16'hFFFE;
    m_rd = 65534;
    c_rd = 16'hFFFE;
    @(posedge clk); #1;
    release dut.rd_count;
    send(2'd0, rand_addr(), n1);
    drain();
    send(2'd2, rand_addr(), n1);
    drain();
    check("rd_count_saturated", 64'(rd_count), 64'hFFFF);

    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 0) drain();
      send(2'($urandom_range(0, 3)), rand_addr(), n1);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout @cycle %0d: got no finish, expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_cmd_sequencer.md
Name: mc_cmd_sequencer

Overview:
- Downstream stage of the memory-controller request queue. It pops one queued request (op + 36-bit address) at a time and decodes the address into channel, bank group, bank, row and column.
- It emits the closed-page DDR5 command sequence with cycle-accurate timing gaps: ACT0, ACT1, RD0/WR0, RD1/WR1, PRE.
- One request is in flight at a time, and the queue is back-pressured through req_ready.

Parameters:
T_RCD, 39, cycles from ACT0 to first CAS (RD0/WR0); must be >=2
T_RTP, 18, cycles from RD0 to PRE; must be >=2
T_CWL, 38, write CAS latency, cycles
T_BURST, 8, burst duration, cycles
T_WR, 72, write recovery, cycles
T_RP, 39, cycles from PRE to next ACT0; must be >=2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  queue head valid
req_ready  out  1  sequencer can accept a request
req_op  in  2  0=read, 1=write, 2=instruction fetch (treated as read), 3=illegal
req_addr  in  36  physical address
cmd_valid  out  1  command issued this cycle
cmd_type  out  3  0=NOP, 1=ACT0, 2=ACT1, 3=RD0, 4=RD1, 5=WR0, 6=WR1, 7=PRE
cmd_channel  out  1  req_addr[6]
cmd_bg  out  3  req_addr[9:7]
cmd_bank  out  2  req_addr[11:10]
cmd_row  out  16  req_addr[33:18]
cmd_col  out  6  req_addr[17:12]
done  out  1  one-cycle pulse coincident with PRE
err  out  1  one-cycle pulse when an op=3 request is accepted
rd_count  out  16  completed reads/fetches, saturating
wr_count  out  16  completed writes, saturating

Behaviour:
- Reset: state IDLE, req_ready=1, cmd_valid=0, cmd_type=0, all cmd fields 0, done=0, err=0, counters 0.
- Reset asserted mid-sequence: the sequence is abandoned immediately and no PRE is issued. Restoring bank state is the caller's responsibility.
- Accept: req_valid && req_ready on edge N latches req_op and the decoded fields. req_ready is 1 only in IDLE.
- Sequence, with A = N+1 as the cycle ACT0 is issued:
  - ACT0 at A; ACT1 at A+1.
  - CAS0 at C = A+T_RCD; CAS1 at C+1.
  - PRE at P:
    - read/fetch: P = C+T_RTP
    - write: P = C+T_CWL+T_BURST+T_WR
  - done=1 at P; rd_count or wr_count increments at P.
- States: IDLE -> ACT0 -> ACT1 -> WAIT_RCD -> CAS0 -> CAS1 -> WAIT_PRE -> PRE -> WAIT_RP -> IDLE.
  - A down-counter, loaded on state entry, drives each WAIT_* exit.
  - WAIT_RP returns to IDLE so that req_ready=1 in cycle P+T_RP-1. A back-to-back accept therefore places the next ACT0 exactly at P+T_RP.
- cmd_valid=1 only in the ACT0, ACT1, CAS0, CAS1 and PRE cycles. Otherwise cmd_type=0.
- cmd_channel, cmd_bg, cmd_bank, cmd_row and cmd_col hold the latched request values from A through P. They are 0 in IDLE.
- cmd_type in CAS cycles: read/fetch uses RD0/RD1 (3/4); write uses WR0/WR1 (5/6).
- Illegal op=3:
  - Accepted, err pulses at N+1, no commands issued.
  - Stays IDLE with req_ready=1 at N+1; counters unchanged.
- Counters saturate at 16'hFFFF.
- Input fields are sampled only on the accept edge; changes on req_* while busy are ignored.
- All outputs are registered.

Test Plan:
- Reset, then read: req_op=0, req_addr=36'h0_0004_0C40 accepted at cycle 0 (defaults) -> ACT0@1, ACT1@2, RD0@40, RD1@41, PRE@58 with done=1; fields channel=1, bg=0, bank=3, col=0, row=1; rd_count=1.
- Write, same address, accepted at 0 -> WR0@40, WR1@41, PRE@158; wr_count=1; req_ready=0 from cycle 1 to 195.
- Back-to-back: two reads, second req_valid held -> second accept edge 96, second ACT0 exactly @97 (PRE@58 + T_RP). Also check req_op=2 produces RD0/RD1 and increments rd_count.
- Illegal: req_op=3 accepted @0 -> err=1@1, cmd_valid=0 throughout, req_ready=1@1, counters unchanged.
- Reset mid-sequence: read accepted @0, rst=1 @20 -> @21 all outputs at reset values, no PRE ever issued; a new read accepted afterwards completes a normal sequence.
- Saturation: force rd_count to 16'hFFFE, run two reads -> rd_count=16'hFFFF after both.
